// File: rtl/imem_program_encoder.sv
// Encodes decoded RV32I field bundles (load/store/R/branch/I/JAL) and writes the
// resulting words to consecutive instruction-memory addresses, reporting done/error.
module imem_program_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // Stream handshake: a bundle transfers on any rising edge where in_valid and
    // in_ready are both 1; in_ready depends only on registered state.

    state_t            state, state_d;
    logic              closing, closing_d;     // final write in flight, leave RUN next
    logic              close_ovf, close_ovf_d; // that final write hit the last address
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W:0]   count_d;
    logic [1:0]        err_d;
    logic              we_d;
    logic              hs;
    logic              type_ok;
    logic              imm_ok;
    logic [31:0]       word;
    logic signed [31:0] simm;

    assign simm      = in_imm;
    assign in_ready  = (state == RUN) && !closing;
    assign hs        = in_valid && in_ready;
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign dbg_state = state;
    assign type_ok   = (in_type <= 3'd5);

    always_comb begin
        word   = '0;
        imm_ok = 1'b0;
        case (in_type)
            3'd0: begin
                word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                imm_ok = (simm >= -2048) && (simm <= 2047);
            end
            3'd1: begin
                word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                imm_ok = (simm >= -2048) && (simm <= 2047);
            end
            3'd2: begin
                word   = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
                imm_ok = 1'b1;
            end
            3'd3: begin
                word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], 7'b1100011};
                imm_ok = (simm >= -4096) && (simm <= 4094) && !in_imm[0];
            end
            3'd4: begin
                word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                imm_ok = (simm >= -2048) && (simm <= 2047);
            end
            3'd5: begin
                word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                imm_ok = (simm >= -1048576) && (simm <= 1048574) && !in_imm[0];
            end
            default: begin
                word   = '0;
                imm_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state;
        closing_d   = closing;
        close_ovf_d = close_ovf;
        ptr_d       = ptr;
        err_d       = err_code;
        we_d        = 1'b0;
        count_d     = count + {{ADDR_W{1'b0}}, mem_we};
        if (start) begin
            // start wins over everything, including a handshake in the same cycle
            state_d     = RUN;
            closing_d   = 1'b0;
            close_ovf_d = 1'b0;
            ptr_d       = '0;
            err_d       = 2'b00;
            count_d     = '0;
        end else if (state == RUN) begin
            if (closing) begin
                state_d   = close_ovf ? ERR : DONE;
                err_d     = close_ovf ? 2'b11 : err_code;
                closing_d = 1'b0;
            end else if (hs) begin
                if (!type_ok) begin
                    state_d = ERR;
                    err_d   = 2'b01;
                end else if (!imm_ok) begin
                    state_d = ERR;
                    err_d   = 2'b10;
                end else begin
                    we_d        = 1'b1;
                    ptr_d       = ptr + 1'b1;
                    closing_d   = in_last || (ptr == LAST_ADDR);
                    close_ovf_d = !in_last && (ptr == LAST_ADDR);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            closing   <= 1'b0;
            close_ovf <= 1'b0;
            ptr       <= '0;
            count     <= '0;
            err_code  <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            closing   <= closing_d;
            close_ovf <= close_ovf_d;
            ptr       <= ptr_d;
            count     <= count_d;
            err_code  <= err_d;
            mem_we    <= we_d;
            if (we_d) begin
                mem_addr  <= ptr;
                mem_wdata <= word;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Bench for imem_program_encoder: directed program/error/overflow scenarios plus
// randomized streams, all checked per cycle against a behavioural model.
module tb_imem_program_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_type = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        in_ready, mem_we, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic [1:0]  err_code, dbg_state;

    logic        in_ready2, mem_we2, done2, error2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;
    logic [1:0]  err_code2, dbg_state2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    logic [39:0] wr_q[$];
    int          wr_cyc[$];
    logic [33:0] wr2_q[$];

    // model state
    int          m_mode = 0;   // 0 idle, 1 run, 2 done, 3 err
    int          m_pend = 0;   // 0 none, 1 finishing normally, 2 finishing on overflow
    int          m_next = 0;
    int          m_count = 0;
    int          m_code = 0;
    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_wdata = '0;

    imem_program_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .done(done), .error(error), .err_code(err_code), .dbg_state(dbg_state)
    );

    imem_program_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .count(count2),
        .done(done2), .error(error2), .err_code(err_code2), .dbg_state(dbg_state2)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_enc(input logic [31:0] t, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] f3, input logic [31:0] f7,
                                              input logic [31:0] u);
        logic [31:0] base;
        base = (rs1 << 15) | (f3 << 12);
        case (t)
            0: return ((u & 32'hFFF) << 20) | base | (rd << 7) | 32'h03;
            4: return ((u & 32'hFFF) << 20) | base | (rd << 7) | 32'h13;
            1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | base | ((u & 32'h1F) << 7) | 32'h23;
            2: return (f7 << 30) | (rs2 << 20) | base | (rd << 7) | 32'h33;
            3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | base
                      | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                      | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_imm_ok(input int t, input int imm);
        case (t)
            0, 1, 4: return (imm >= -2048) && (imm <= 2047);
            2:       return 1'b1;
            3:       return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
            5:       return (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    // behavioural model of the 256-word instance
    always @(posedge clk) begin
        bit rdy;
        int nc;
        int t;
        int imm;
        rdy = (m_mode == 1) && (m_pend == 0);
        nc  = m_count + (m_we ? 1 : 0);
        t   = int'(in_type);
        imm = $signed(in_imm);
        if (reset) begin
            m_mode = 0; m_pend = 0; m_next = 0; m_count = 0; m_code = 0;
            m_we = 0; m_addr = 0; m_wdata = '0;
        end else if (start) begin
            m_mode = 1; m_pend = 0; m_next = 0; m_count = 0; m_code = 0; m_we = 0;
        end else begin
            m_count = nc;
            m_we = 0;
            if (m_mode == 1 && m_pend != 0) begin
                if (m_pend == 1) m_mode = 2;
                else begin m_mode = 3; m_code = 3; end
                m_pend = 0;
            end else if (rdy && in_valid) begin
                if (t > 5) begin
                    m_mode = 3; m_code = 1;
                end else if (!model_imm_ok(t, imm)) begin
                    m_mode = 3; m_code = 2;
                end else begin
                    m_we = 1;
                    m_addr = m_next;
                    m_wdata = model_enc(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm);
                    if (in_last) m_pend = 1;
                    else if (m_next == 255) m_pend = 2;
                    m_next++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // scoreboard: per-cycle compare and write logs
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, (m_mode == 1) && (m_pend == 0));
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("count", count, m_count);
            check("done", done, m_mode == 2);
            check("error", error, m_mode == 3);
            check("err_code", err_code, m_code);
        end
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
        if (mem_we2) wr2_q.push_back({mem_addr2, mem_wdata2});
    end

    // driver tasks
    task automatic do_reset();
        reset = 1; start = 0; in_valid = 0;
        @(negedge clk); @(negedge clk);
        reset = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic clear_logs();
        wr_q.delete(); wr_cyc.delete(); wr2_q.delete();
    endtask

    task automatic send(input int t, input int rd, input int rs1, input int rs2, input int f3,
                        input int f7, input int imm, input bit last);
        in_type = 3'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7b5 = f7[0]; in_imm = imm; in_last = last;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_wr(input string nm, input int i, input int addr, input logic [31:0] data);
        if (i < wr_q.size()) begin
            check({nm, "_addr"}, wr_q[i][39:32], addr);
            check({nm, "_data"}, wr_q[i][31:0], data);
        end else begin
            check({nm, "_present"}, 0, 1);
        end
    endtask

    int bnd[13] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                    1048574, -1048576, 1048576, -1048578};

    function automatic int rand_imm();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 200)) - 100;
            1: return bnd[$urandom_range(0, 12)];
            2: return (int'($urandom_range(0, 4000)) - 2000) * 2;
            3: return int'($urandom_range(0, 40)) * 2;
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        do_reset();
        chk_en = 1;
        check("rst_ready", in_ready, 0);
        check("rst_count", count, 0);

        // small program with done
        pulse_start(); clear_logs();
        send(4, 1, 0, 0, 0, 0, 5, 0);
        send(0, 2, 1, 0, 2, 0, 8, 0);
        send(1, 0, 1, 2, 2, 0, 4, 1);
        idle(3);
        check("p1_nwr", wr_q.size(), 3);
        check_wr("p1_w0", 0, 0, 32'h00500093);
        check_wr("p1_w1", 1, 1, 32'h0080A103);
        check_wr("p1_w2", 2, 2, 32'h0020A223);
        if (wr_cyc.size() == 3) check("p1_consec", wr_cyc[2] - wr_cyc[0], 2);
        check("p1_count", count, 3);
        check("p1_done", done, 1);

        // R-type, branch, JAL back-to-back
        pulse_start(); clear_logs();
        send(2, 3, 1, 2, 0, 0, 0, 0);
        send(2, 3, 1, 2, 0, 1, 0, 0);
        send(3, 0, 1, 2, 0, 0, -4, 0);
        send(5, 1, 0, 0, 0, 0, 8, 1);
        idle(3);
        check("p2_nwr", wr_q.size(), 4);
        check_wr("p2_add", 0, 0, 32'h002081B3);
        check_wr("p2_sub", 1, 1, 32'h402081B3);
        check_wr("p2_beq", 2, 2, 32'hFE208EE3);
        check_wr("p2_jal", 3, 3, 32'h008000EF);
        if (wr_cyc.size() == 4) check("p2_consec", wr_cyc[3] - wr_cyc[0], 3);

        // faulting second bundle
        for (int k = 0; k < 3; k++) begin
            pulse_start(); clear_logs();
            send(4, 1, 0, 0, 0, 0, 5, 0);
            if (k == 0) send(4, 1, 0, 0, 0, 0, 2048, 0);
            else if (k == 1) send(3, 0, 1, 2, 0, 0, 3, 0);
            else send(6, 1, 0, 0, 0, 0, 0, 0);
            idle(3);
            check("e_error", error, 1);
            check("e_code", err_code, (k == 2) ? 1 : 2);
            check("e_count", count, 1);
            check("e_nwr", wr_q.size(), 1);
        end

        // overflow on the 4-word instance
        pulse_start(); clear_logs();
        for (int k = 0; k < 5; k++) send(4, k + 1, 0, 0, 0, 0, k, 0);
        idle(3);
        check("ov_nwr", wr2_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < wr2_q.size()) check("ov_addr", wr2_q[k][33:32], k);
        check("ov_count", count2, 4);
        check("ov_error", error2, 1);
        check("ov_code", err_code2, 3);
        check("ov_ready", in_ready2, 0);

        // restart mid-program
        pulse_start(); clear_logs();
        send(4, 1, 0, 0, 0, 0, 1, 0);
        send(4, 2, 0, 0, 0, 0, 2, 0);
        idle(1);
        pulse_start();
        send(4, 3, 0, 0, 0, 0, 3, 0);
        idle(3);
        check("rs_count", count, 1);
        if (wr_q.size() > 0) check("rs_addr", wr_q[wr_q.size()-1][39:32], 0);
        check("rs_done", done, 0);
        check("rs_error", error, 0);

        // reset during a write cycle
        pulse_start();
        send(4, 1, 0, 0, 0, 0, 5, 0);
        check("rw_we_before", mem_we, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rw_we", mem_we, 0);
        check("rw_wdata", mem_wdata, 0);
        idle(3);
        check("rw_ready", in_ready, 0);

        // randomized streams
        pulse_start();
        for (int i = 0; i < 4000; i++) begin
            start = (!in_ready && $urandom_range(0, 7) == 0) || ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 999) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
            in_funct3 = 3'($urandom); in_funct7b5 = 1'($urandom);
            in_imm = rand_imm();
            in_last = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        start = 0; reset = 0; in_valid = 0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_program_encoder.md
# imem_program_encoder

Sequential instruction encoder and instruction-memory loader for the 5-stage RISC-V core. It accepts decoded instruction fields over a valid/ready stream and assembles RV32I words for the six instruction classes the main control decoder supports: load, store, R-type, branch, I-type ALU and JAL. Each word is written into instruction memory at consecutive word addresses. It is used by bring-up benches and boot logic to build programs the core then fetches and decodes.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; clears pointer/status and enters RUN
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_type  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6–7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3 field (unused for JAL)
- in_funct7b5  in  1  instr[30] for RTYPE; ignored otherwise
- in_imm  in  32  signed byte-offset/immediate
- in_last  in  1  marks final instruction of program
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- done  out  1  program fully written
- error  out  1  load aborted
- err_code  out  2  01 illegal type, 10 immediate out of range, 11 memory overflow

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111.
- Formats: LOAD/ITYPE {imm[11:0],rs1,f3,rd,op}; STORE {imm[11:5],rs2,rs1,f3,imm[4:0],op}; RTYPE {0,f7b5,00000,rs2,rs1,f3,rd,op}; BRANCH {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range checks on the signed 32-bit in_imm: LOAD/STORE/ITYPE -2048..2047; BRANCH -4096..4094 and even; JAL -1048576..1048574 and even. RTYPE ignores in_imm.
- FSM states: IDLE, RUN, DONE, ERR.
  - IDLE: in_ready=0. start → RUN.
  - RUN: in_ready=1. On handshake (in_valid&in_ready), a legal bundle is registered for writing. An illegal type or out-of-range imm → ERR with the matching err_code. The faulting bundle is never written, and count is not advanced.
  - Accepting in_last → DONE after its write.
  - Accepting the bundle destined for address 2^ADDR_W-1 without in_last → that word is written, then ERR with code 11.
  - DONE: done=1, in_ready=0; held until start or reset.
  - ERR: error=1, err_code held, in_ready=0; held until start or reset.
- start has priority in every state, including mid-program in RUN. It clears count, pointer, done, error and err_code, and cancels any pending write. Next state is RUN.
- Address pointer increments per write. In-range addresses do not wrap; overflow is reported instead.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, error=0, err_code=00; state IDLE.
- Handshake at edge N → mem_we=1 during cycle N+1 with mem_addr=index and mem_wdata=word. count increments at the end of that cycle.
- Throughput is one bundle per cycle; back-to-back handshakes produce back-to-back writes.
- in_ready rises the cycle after start. It drops the cycle after handshaking in_last, an error, or the last-address bundle.
- done/error assert in the cycle after the final write or the faulting handshake.
- mem_we is 1 only for the write cycle; mem_addr/mem_wdata hold their last values otherwise.
- reset mid-RUN: the pending write is dropped and all outputs return to reset values the next cycle.

## Test plan
- start; stream addi x1,x0,5; lw x2,8(x1); sw x2,4(x1) (last) → writes 0x00500093@0, 0x0080A103@1, 0x0020A223@2 on consecutive cycles; count=3; done=1.
- Back-to-back add x3,x1,x2 / sub x3,x1,x2 / beq x1,x2,-4 / jal x1,8 (last) → 0x002081B3, 0x402081B3, 0xFE208EE3, 0x008000EF at addresses 0..3; one write per cycle.
- ITYPE imm=2048 as second bundle → no write for it; error=1, err_code=10, count=1. Repeat with BRANCH imm=3 (odd) → same. Repeat with in_type=6 → err_code=01.
- ADDR_W=2: stream 5 bundles, none with in_last → 4 writes at 0..3, then err_code=11, count=4, in_ready=0.
- start pulsed after 2 writes in RUN → count=0, next write goes to address 0; done and error stay 0.
- Assert reset during a write cycle → mem_we=0 and all outputs at reset values the next cycle; in_ready=0 until the next start.
